// File: rtl/riscv_pc_unit.sv
// Program-counter unit: PC register, next-PC selection, stall with a one-deep redirect buffer, and misalignment trap.
// Optional return-address stack is enabled with the RISCV_PC_UNIT_RAS_EN macro.
module riscv_pc_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              IALIGN    = 32,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] pc_ex,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            is_call,
  input  logic            is_ret,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] pcrel,
  output logic            valid,
  output logic            misalign
);

  typedef enum logic [1:0] {BOOT, RUN, HELD} state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] pend_target_reg, pend_target_next;
  logic            pend_mis_reg, pend_mis_next;
  logic            misalign_reg, misalign_next;

  logic [XLEN-1:0] jalr_target, jalr_sel;
  logic [XLEN-1:0] raw_target, new_target;
  logic            check_align, new_mis, redirect;

  function automatic logic is_misaligned(input logic [XLEN-1:0] t);
    if (IALIGN == 16) return t[0];
    else              return |t[1:0];
  endfunction

  assign pc_plus4    = pc_reg + XLEN'(4);
  assign pcrel       = pc_ex + imm;
  assign jalr_target = (rs1 + imm) & {{(XLEN-1){1'b1}}, 1'b0};
  assign redirect    = (pc_src != 2'b00);

`ifdef RISCV_PC_UNIT_RAS_EN
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   ras_wr_reg, ras_wr_next, ras_push_idx, ras_top_idx;
  logic [CW-1:0]   ras_count_reg, ras_count_next;
  logic [XLEN-1:0] ras_top;
  logic            ras_accept, do_pop, do_push;

  function automatic logic [PW-1:0] ras_inc(input logic [PW-1:0] i);
    return (i == PW'(RAS_DEPTH - 1)) ? '0 : i + PW'(1);
  endfunction

  function automatic logic [PW-1:0] ras_dec(input logic [PW-1:0] i);
    return (i == '0) ? PW'(RAS_DEPTH - 1) : i - PW'(1);
  endfunction

  // The stack only moves on the edge a redirect actually reaches the PC.
  assign ras_accept  = (state_reg != BOOT) && !stall && redirect;
  assign do_pop      = ras_accept && is_ret && (pc_src == 2'b10);
  assign do_push     = ras_accept && is_call;
  assign ras_top_idx = ras_dec(ras_wr_reg);
  assign ras_top     = ras_mem[ras_top_idx];
  assign jalr_sel    = (is_ret && (ras_count_reg != '0) && (ras_top == jalr_target))
                       ? ras_top : jalr_target;

  always_comb begin
    ras_wr_next    = ras_wr_reg;
    ras_count_next = ras_count_reg;
    if (do_pop && (ras_count_reg != '0)) begin
      ras_wr_next    = ras_dec(ras_wr_reg);
      ras_count_next = ras_count_reg - CW'(1);
    end
    ras_push_idx = ras_wr_next;
    if (do_push) begin
      ras_wr_next = ras_inc(ras_push_idx);
      if (ras_count_next != CW'(RAS_DEPTH))
        ras_count_next = ras_count_next + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ras_wr_reg    <= '0;
      ras_count_reg <= '0;
    end else begin
      ras_wr_reg    <= ras_wr_next;
      ras_count_reg <= ras_count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) ras_mem[ras_push_idx] <= pc_ex + XLEN'(4);
  end
`else
  localparam int unused_ras_depth = RAS_DEPTH;
  logic unused_ras_inputs;
  assign unused_ras_inputs = is_call ^ is_ret;
  assign jalr_sel          = jalr_target;
`endif

  // Resolved redirect target; a misaligned branch/jump target falls back to trap_vec.
  always_comb begin
    raw_target  = pc_plus4;
    check_align = 1'b0;
    case (pc_src)
      2'b01:   begin raw_target = pcrel;    check_align = 1'b1; end
      2'b10:   begin raw_target = jalr_sel; check_align = 1'b1; end
      2'b11:   raw_target = trap_vec;
      default: raw_target = pc_plus4;
    endcase
    new_mis    = check_align && is_misaligned(raw_target);
    new_target = new_mis ? trap_vec : raw_target;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= BOOT;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      BOOT:    state_next = RUN;
      RUN:     if (stall && redirect) state_next = HELD;
      HELD:    if (!stall) state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  always_comb begin
    pc_next          = pc_reg;
    pend_target_next = pend_target_reg;
    pend_mis_next    = pend_mis_reg;
    misalign_next    = 1'b0;
    case (state_reg)
      RUN: begin
        if (!stall) begin
          pc_next       = new_target;
          misalign_next = new_mis;
        end else if (redirect) begin
          pend_target_next = new_target;
          pend_mis_next    = new_mis;
        end
      end
      HELD: begin
        if (!stall) begin
          // A fresh redirect on the release edge outranks the buffered one.
          pc_next          = redirect ? new_target : pend_target_reg;
          misalign_next    = redirect ? new_mis    : pend_mis_reg;
          pend_target_next = '0;
          pend_mis_next    = 1'b0;
        end else if (redirect) begin
          pend_target_next = new_target;
          pend_mis_next    = new_mis;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg          <= RESET_VEC;
      pend_target_reg <= '0;
      pend_mis_reg    <= 1'b0;
      misalign_reg    <= 1'b0;
    end else begin
      pc_reg          <= pc_next;
      pend_target_reg <= pend_target_next;
      pend_mis_reg    <= pend_mis_next;
      misalign_reg    <= misalign_next;
    end
  end

  always_comb begin
    valid = (state_reg != BOOT);
  end

  assign pc       = pc_reg;
  assign misalign = misalign_reg;

endmodule

// File: doc/riscv_pc_unit.md
Name: riscv_pc_unit

Overview:
- Parametrised program-counter unit for the RISC-V cores. It replaces the fixed 32-bit, always-PC+4 update of the single-cycle datapath.
- Holds the PC register and computes the PC-relative result for AUIPC/JAL/branch targets.
- Supports stall, a one-deep buffered redirect taken while stalled, and detection of misaligned targets.
- Sits between the control unit (pc_src) and instruction memory. Used by both the single-cycle and the pipelined datapaths.

Parameters:
- XLEN, 32, datapath and PC width in bits (32 or 64).
- RESET_VEC, 0, PC value loaded on reset, XLEN bits.
- IALIGN, 32, instruction alignment in bits (32 or 16). Sets which target bits are checked for misalignment.
- RAS_DEPTH, 4, entries in the return-address stack (used only with RAS_EN).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  hold the PC; any redirect requested this cycle is buffered.
- pc_src  in  2  00 PC+4, 01 pc_ex+imm (branch/JAL), 10 (rs1+imm)&~1 (JALR), 11 trap_vec.
- pc_ex  in  XLEN  PC of the instruction being executed (equals pc in single-cycle).
- imm  in  XLEN  sign-extended immediate (U-type already shifted left by 12).
- rs1  in  XLEN  rs1 operand for JALR.
- trap_vec  in  XLEN  trap target.
- is_call  in  1  instruction is JAL/JALR with rd=x1/x5 (RAS only).
- is_ret  in  1  instruction is JALR x0,0(x1/x5) (RAS only).
- pc  out  XLEN  current fetch PC.
- pc_plus4  out  XLEN  pc+4, combinational.
- pcrel  out  XLEN  pc_ex+imm, combinational; the AUIPC result and branch target.
- valid  out  1  pc is a legal fetch address this cycle.
- misalign  out  1  one-cycle pulse: a redirect target was misaligned and the trap vector was taken instead.

Behaviour:
- Reset (rst=0), asynchronous: pc=RESET_VEC, valid=0, misalign=0, pending buffer cleared, RAS pointer=0, state=BOOT.
- State BOOT lasts exactly one rising edge after rst goes high: pc is held, valid=0, then state goes to RUN with valid=1. The first instruction is fetched at RESET_VEC on the cycle after that edge.
- State RUN, stall=0: pc loads the next-PC selected by pc_src. There is one edge of latency from pc_src to pc.
- State RUN, stall=1 with pc_src=00: pc is held.
- State RUN, stall=1 with pc_src!=00: the target is latched into the pending buffer and state goes to HELD. pc is held.
- State HELD:
  - While stall=1, pc is held.
  - New redirects overwrite the pending target; the last one wins. pc_src=00 does not clear the buffer.
  - On the first edge with stall=0, pc loads the pending target, the buffer clears, and state returns to RUN.
  - If a new non-00 pc_src is present on that same edge, the new redirect has priority over the pending target.
- Target arithmetic is modulo 2^XLEN, with no overflow flag. For example, 0xFFFFFFFC+4 wraps to 0 at XLEN=32.
- JALR target: bit 0 is cleared before the alignment check.
- Misalignment check:
  - Fails if target[1:0]!=0 when IALIGN=32, or target[0]!=0 when IALIGN=16.
  - On failure the PC loads trap_vec instead of the target, and misalign pulses for one cycle, aligned with the PC update.
  - A misaligned trap_vec is loaded unchanged, with no pulse.
- pcrel is always pc_ex+imm, independent of stall, state and reset. Example: pc_ex=0 with U-immediate 0x0ffff000 gives pcrel=0x0ffff000.
- Reset asserted mid-operation aborts any pending redirect. No state survives except RAS contents, which become don't-care.

Optional Feature:
- Macro: RISCV_PC_UNIT_RAS_EN.
- Defined: adds a RAS_DEPTH-entry circular return-address stack.
  - is_call pushes pc_ex+4 when the redirect is accepted.
  - is_ret with pc_src=10 uses the top-of-stack entry as the target (popping it) only when it equals the computed JALR target. On a mismatch the computed target is used and the stack is still popped.
  - A push onto a full stack overwrites the oldest entry (wrap-around).
  - A pop from an empty stack leaves the pointer at 0 and uses the computed target.
  - Simultaneous is_call and is_ret: pop, then push.
- Undefined: is_call and is_ret are ignored, and no RAS storage is synthesised.

Test Plan:
- Reset, then release: pc=0 with valid=0 for one edge, then valid=1; after the next edge with pc_src=00, pc=4.
- pc=0, imm=0x0ffff000, pc_src=00: pcrel=0x0ffff000; with pc_src=01 instead, pc=0x0ffff000 after one edge.
- JALR with rs1=13, imm=0, IALIGN=32: target 12, pc=12, misalign=0. With rs1=14: pc=trap_vec (0x100) and misalign pulses for one cycle.
- stall=1 with pc_src=01 to target 0x40, then pc_src=00 for 3 cycles, then stall=0: pc holds for all stalled cycles, then loads 0x40 on the release edge.
- pc=0xFFFFFFFC, pc_src=00: pc=0 after one edge, with no error.
- RAS_EN defined: two calls from pc_ex 0x10 and 0x20, then a return with rs1=0x24: pc=0x24 and the stack pointer ends at 1. Five pushes at RAS_DEPTH=4 overwrite the oldest entry.
